// File: rtl/miniRISC_pkg.sv
// Shared definitions for the KGP_miniRISC PC stage and BranchDecider:
// datapath defaults, PC-stage state encoding and short-branch type codes.
package miniRISC_pkg;

  localparam int unsigned PC_WIDTH_DEF = 32;
  localparam int unsigned OFF_WIDTH_DEF = 16;
  localparam int unsigned RESET_PC_DEF = 0;
  localparam int unsigned STEP_DEF = 1;
  localparam int unsigned CNT_WIDTH = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } pc_state_e;

  // Short-branch condition codes, decoded by BranchDecider
  typedef enum logic [1:0] {
    SHORT_BR_LTZ = 2'b01,
    SHORT_BR_Z   = 2'b10,
    SHORT_BR_NZ  = 2'b11
  } short_br_type_e;

  // Saturating increment for the optional statistics counters
  function automatic logic [CNT_WIDTH-1:0] satInc(input logic [CNT_WIDTH-1:0] value);
    if (&value) begin
      return value;
    end
    return value + CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/pc_adder.sv
// Combinational PC arithmetic: sequential successor and sign-extended
// PC-relative branch target, both modulo 2^PC_WIDTH.
module pc_adder #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned OFF_WIDTH = 16,
  parameter int unsigned STEP      = 1
) (
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic [OFF_WIDTH-1:0] off,
  output logic [PC_WIDTH-1:0]  pcStep,
  output logic [PC_WIDTH-1:0]  pcBranch
);

  logic [PC_WIDTH-1:0] offExt;

  assign offExt   = {{(PC_WIDTH-OFF_WIDTH){off[OFF_WIDTH-1]}}, off};
  assign pcStep   = pc + PC_WIDTH'(STEP);
  assign pcBranch = pc + offExt;

endmodule

// File: rtl/pc_next_unit.sv
// PC register and next-PC selection with link and HALT handling.
// Optional branch/instruction counters are enabled by defining BRANCH_STATS_EN.
module pc_next_unit
  import miniRISC_pkg::*;
#(
  parameter int unsigned          PC_WIDTH  = PC_WIDTH_DEF,
  parameter int unsigned          OFF_WIDTH = OFF_WIDTH_DEF,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = PC_WIDTH'(RESET_PC_DEF),
  parameter int unsigned          STEP      = STEP_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 br_taken,
  input  logic [OFF_WIDTH-1:0] short_off,
  input  logic                 long_br,
  input  logic [PC_WIDTH-1:0]  long_target,
  input  logic                 link,
  output logic [PC_WIDTH-1:0]  pc,
  output logic [PC_WIDTH-1:0]  ret_addr,
  output logic                 ret_we,
  output logic                 redirect,
  output logic                 halted
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]          taken_cnt,
  output logic [31:0]          long_cnt,
  output logic [31:0]          instr_cnt
`endif
);

  pc_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] retAddr_q, retAddr_d;
  logic                retWe_q, retWe_d;
  logic                redirect_q, redirect_d;
  logic [PC_WIDTH-1:0] pcStep;
  logic [PC_WIDTH-1:0] pcBranch;

  pc_adder #(
    .PC_WIDTH  (PC_WIDTH),
    .OFF_WIDTH (OFF_WIDTH),
    .STEP      (STEP)
  ) u_pc_adder (
    .pc       (pc_q),
    .off      (short_off),
    .pcStep   (pcStep),
    .pcBranch (pcBranch)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      retAddr_q  <= '0;
      retWe_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      retAddr_q  <= retAddr_d;
      retWe_q    <= retWe_d;
      redirect_q <= redirect_d;
    end
  end

  // Pulses default low so stall and HALTED cycles never re-issue them
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    retAddr_d  = retAddr_q;
    retWe_d    = 1'b0;
    redirect_d = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!stall) begin
          if (halt) begin
            state_d = HALTED;
          end else if (long_br || br_taken) begin
            pc_d       = long_br ? long_target : pcBranch;
            redirect_d = 1'b1;
            if (link) begin
              retAddr_d = pcStep;
              retWe_d   = 1'b1;
            end
          end else begin
            pc_d = pcStep;
          end
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc       = pc_q;
  assign ret_addr = retAddr_q;
  assign ret_we   = retWe_q;
  assign redirect = redirect_q;
  assign halted   = (state_q == HALTED);

`ifdef BRANCH_STATS_EN
  logic              retireEvt;
  logic              longEvt;
  logic              takenEvt;
  logic [31:0]       takenCnt_q, takenCnt_d;
  logic [31:0]       longCnt_q, longCnt_d;
  logic [31:0]       instrCnt_q, instrCnt_d;

  // HALT retires; long_br outranks br_taken so each branch counts once
  assign retireEvt = (state_q == RUN) && !stall;
  assign longEvt   = retireEvt && !halt && long_br;
  assign takenEvt  = retireEvt && !halt && !long_br && br_taken;

  always_comb begin
    takenCnt_d = takenCnt_q;
    longCnt_d  = longCnt_q;
    instrCnt_d = instrCnt_q;
    if (takenEvt) begin
      takenCnt_d = satInc(takenCnt_q);
    end
    if (longEvt) begin
      longCnt_d = satInc(longCnt_q);
    end
    if (retireEvt) begin
      instrCnt_d = satInc(instrCnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      takenCnt_q <= '0;
      longCnt_q  <= '0;
      instrCnt_q <= '0;
    end else begin
      takenCnt_q <= takenCnt_d;
      longCnt_q  <= longCnt_d;
      instrCnt_q <= instrCnt_d;
    end
  end

  assign taken_cnt = takenCnt_q;
  assign long_cnt  = longCnt_q;
  assign instr_cnt = instrCnt_q;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: a behavioural reference model queues the
// expected outputs for each driven cycle, which are compared after the edge.
module tb_pc_next_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] retAddr;
    logic        retWe;
    logic        redirect;
    logic        halted;
    logic [31:0] takenCnt;
    logic [31:0] longCnt;
    logic [31:0] instrCnt;
  } expect_t;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        halt;
  logic        br_taken;
  logic [15:0] short_off;
  logic        long_br;
  logic [31:0] long_target;
  logic        link;
  logic [31:0] pc;
  logic [31:0] ret_addr;
  logic        ret_we;
  logic        redirect;
  logic        halted;
`ifdef BRANCH_STATS_EN
  logic [31:0] taken_cnt;
  logic [31:0] long_cnt;
  logic [31:0] instr_cnt;
`endif

  int checkCount = 0;
  int passCount  = 0;

  expect_t     scoreboard[$];
  logic [31:0] mPc = 32'h0;
  logic [31:0] mRet = 32'h0;
  logic        mHalted = 1'b0;
  logic [31:0] mTaken = 32'h0;
  logic [31:0] mLong = 32'h0;
  logic [31:0] mInstr = 32'h0;

  pc_next_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .halt        (halt),
    .br_taken    (br_taken),
    .short_off   (short_off),
    .long_br     (long_br),
    .long_target (long_target),
    .link        (link),
    .pc          (pc),
    .ret_addr    (ret_addr),
    .ret_we      (ret_we),
    .redirect    (redirect),
    .halted      (halted)
`ifdef BRANCH_STATS_EN
    ,
    .taken_cnt   (taken_cnt),
    .long_cnt    (long_cnt),
    .instr_cnt   (instr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs, advances the model, queues its prediction,
  // then compares the DUT against the popped entry just after the edge.
  task automatic applyStimulus(input logic rstN, input logic stallI, input logic haltI,
                               input logic brI, input logic [15:0] off, input logic longI,
                               input logic [31:0] tgt, input logic linkI);
    expect_t e;
    expect_t got;
    logic    we;
    logic    rd;
    rst_n = rstN; stall = stallI; halt = haltI; br_taken = brI;
    short_off = off; long_br = longI; long_target = tgt; link = linkI;
    we = 1'b0;
    rd = 1'b0;
    if (!rstN) begin
      mPc = 32'h0; mRet = 32'h0; mHalted = 1'b0;
      mTaken = 32'h0; mLong = 32'h0; mInstr = 32'h0;
    end else if (!mHalted && !stallI) begin
      if (mInstr != 32'hFFFF_FFFF) mInstr = mInstr + 32'd1;
      if (haltI) begin
        mHalted = 1'b1;
      end else if (longI || brI) begin
        rd = 1'b1;
        if (linkI) begin
          mRet = mPc + 32'd1;
          we   = 1'b1;
        end
        if (longI) begin
          mPc = tgt;
          if (mLong != 32'hFFFF_FFFF) mLong = mLong + 32'd1;
        end else begin
          mPc = mPc + {{16{off[15]}}, off};
          if (mTaken != 32'hFFFF_FFFF) mTaken = mTaken + 32'd1;
        end
      end else begin
        mPc = mPc + 32'd1;
      end
    end
    e.pc = mPc; e.retAddr = mRet; e.retWe = we; e.redirect = rd; e.halted = mHalted;
    e.takenCnt = mTaken; e.longCnt = mLong; e.instrCnt = mInstr;
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    got = scoreboard.pop_front();
    checkOutput("pc", pc, got.pc);
    checkOutput("ret_addr", ret_addr, got.retAddr);
    checkOutput("ret_we", {31'b0, ret_we}, {31'b0, got.retWe});
    checkOutput("redirect", {31'b0, redirect}, {31'b0, got.redirect});
    checkOutput("halted", {31'b0, halted}, {31'b0, got.halted});
`ifdef BRANCH_STATS_EN
    checkOutput("taken_cnt", taken_cnt, got.takenCnt);
    checkOutput("long_cnt", long_cnt, got.longCnt);
    checkOutput("instr_cnt", instr_cnt, got.instrCnt);
`endif
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic longTo(input logic [31:0] tgt);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, tgt, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; halt = 1'b0; br_taken = 1'b0;
    short_off = 16'h0; long_br = 1'b0; long_target = 32'h0; link = 1'b0;
    @(posedge clk);
    #1;

    // Reset wins over branch requests
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 16'h4, 1'b1, 32'h55, 1'b1);
    checkOutput("reset_pc", pc, 32'h0);

    repeat (3) idle();
    checkOutput("seq_pc3", pc, 32'h3);

    // Backward short branch relative to the branch's own PC
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFE, 1'b0, 32'h0, 1'b0);
    checkOutput("short_back_pc", pc, 32'h1);
    checkOutput("short_redirect", {31'b0, redirect}, 32'h1);
    idle();
    checkOutput("redirect_drop", {31'b0, redirect}, 32'h0);

    repeat (3) idle();
    checkOutput("pc5", pc, 32'h5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 32'h40, 1'b1);
    checkOutput("bal_pc", pc, 32'h40);
    checkOutput("bal_ret", ret_addr, 32'h6);
    checkOutput("bal_we", {31'b0, ret_we}, 32'h1);
    idle();
    checkOutput("bal_we_drop", {31'b0, ret_we}, 32'h0);
    // Link without an accepted branch leaves ret_addr alone
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b1);

    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h99, 1'b1);
    checkOutput("stall_pc", pc, 32'h42);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h7, 1'b1, 32'h80, 1'b0);
    checkOutput("long_over_short", pc, 32'h80);
    // Short branch with link, forward offset
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 1'b0, 32'h0, 1'b1);

    longTo(32'h9);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 32'h20, 1'b1);
    checkOutput("halt_pc", pc, 32'h9);
    checkOutput("halt_flag", {31'b0, halted}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h3, 1'b0, 32'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h30, 1'b0);
    longTo(32'h44);
    checkOutput("halted_frozen", pc, 32'h9);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    checkOutput("halt_reset_flag", {31'b0, halted}, 32'h0);

    longTo(32'hFFFF_FFFF);
    idle();
    checkOutput("wrap_up", pc, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b0, 32'h0, 1'b0);
    checkOutput("wrap_down", pc, 32'hFFFF_FFFF);

    // Counter scenario: 2 short-taken, 1 long, 1 stalled long
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h2, 1'b0, 32'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 16'h3, 1'b0, 32'h0, 1'b0);
    longTo(32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 32'h200, 1'b0);
    checkOutput("stats_pc", pc, 32'h100);
`ifdef BRANCH_STATS_EN
    checkOutput("stats_taken", taken_cnt, 32'd2);
    checkOutput("stats_long", long_cnt, 32'd1);
    checkOutput("stats_instr", instr_cnt, 32'd3);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
